// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR filter family:
// sequencer states, width helpers and the round/saturate output scaling.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } firState_t;

    // Working width for roundSat; must exceed any accumulator width handed to it.
    localparam int RS_MAX_W = 128;

    function automatic int accWidth(input int n, input int taps);
        return 2 * n + $clog2(taps);
    endfunction

    function automatic int chanWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic logic signed [RS_MAX_W-1:0] roundSat(
        input logic signed [RS_MAX_W-1:0] acc,
        input int                         n,
        input int                         frac
    );
        logic signed [RS_MAX_W-1:0] one;
        logic signed [RS_MAX_W-1:0] rounded;
        logic signed [RS_MAX_W-1:0] maxVal;
        logic signed [RS_MAX_W-1:0] minVal;
        one     = RS_MAX_W'(1);
        rounded = acc + (one <<< (frac - 1));
        rounded = rounded >>> frac;
        maxVal  = (one <<< (n - 1)) - one;
        minVal  = -(one <<< (n - 1));
        if (rounded > maxVal) begin
            return maxVal;
        end
        if (rounded < minVal) begin
            return minVal;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output scaling: round half toward +inf at FRAC, then clamp
// to the signed N-bit range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int N     = 32,
    parameter int FRAC  = 16,
    parameter int ACC_W = 66
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [N-1:0]     y_o
);

    logic signed [RS_MAX_W-1:0] accWide;

    assign accWide = {{(RS_MAX_W - ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign y_o     = N'(roundSat(accWide, N, FRAC));

endmodule

// File: rtl/fir_mc_tdm.sv
// Time-multiplexed multi-channel FIR: one shared multiply-accumulate iterated
// over TAPS cycles per sample, with run-time coefficients and valid/ready I/O.
module fir_mc_tdm
    import fir_pkg::*;
#(
    parameter int N        = 32,
    parameter int TAPS     = 4,
    parameter int CHANNELS = 2,
    parameter int FRAC     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           coef_we,
    input  logic [$clog2(TAPS)-1:0]        coef_addr,
    input  logic signed [N-1:0]            coef_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [chanWidth(CHANNELS)-1:0] in_ch,
    input  logic signed [N-1:0]            x_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [chanWidth(CHANNELS)-1:0] out_ch,
    output logic signed [N-1:0]            y_out,
    output logic                           busy
);

    localparam int ACC_W  = accWidth(N, TAPS);
    localparam int CH_W   = chanWidth(CHANNELS);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int PROD_W = 2 * N;

    firState_t                state_q, state_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [N-1:0]      y_q, y_d;
    logic [CH_W-1:0]          outCh_q, outCh_d;
    logic                     outValid_q, outValid_d;

    logic signed [N-1:0]      coef_q [TAPS];
    logic signed [N-1:0]      x_q    [CHANNELS][TAPS];

    logic                     chanOk;
    logic                     coefAddrOk;
    logic                     accept;
    logic                     shiftEn;
    logic                     coefWrite;
    logic signed [PROD_W-1:0] product;
    logic signed [N-1:0]      roundedY;

    // Comparisons are widened by one bit so they stay meaningful when the
    // parameter is an exact power of two.
    assign chanOk     = ({1'b0, in_ch} < (CH_W + 1)'(CHANNELS));
    assign coefAddrOk = ({1'b0, coef_addr} < (TAP_W + 1)'(TAPS));

    assign in_ready  = rst && ena && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign shiftEn   = accept && chanOk;
    assign coefWrite = coef_we && coefAddrOk && (state_q == IDLE);

    assign product = PROD_W'(coef_q[tap_q]) * PROD_W'(x_q[ch_q][tap_q]);

    fir_round_sat #(
        .N     (N),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_roundSat (
        .acc_i (acc_q),
        .y_o   (roundedY)
    );

    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign y_out     = y_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        ch_d       = ch_q;
        acc_d      = acc_q;
        y_d        = y_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (shiftEn) begin
                        ch_d    = in_ch;
                        acc_d   = '0;
                        tap_d   = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    acc_d = acc_q + ACC_W'(product);
                    if (tap_q == TAP_W'(TAPS - 1)) begin
                        state_d = FIN;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                FIN: begin
                    y_d        = roundedY;
                    outCh_d    = ch_q;
                    outValid_d = 1'b1;
                    state_d    = OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        outValid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
        end
    end

    // Coefficient writes only land while idle so a running sum never sees a mixed set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= '0;
            end
        end else if (coefWrite) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    x_q[c][t] <= '0;
                end
            end
        end else if (shiftEn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (CH_W'(c) == in_ch) begin
                    x_q[c][0] <= x_in;
                    for (int t = 1; t < TAPS; t++) begin
                        x_q[c][t] <= x_q[c][t-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mc_tdm.sv
// Self-checking bench for fir_mc_tdm: expected results are queued at each
// accept and compared against every output handshake.
module tb_fir_mc_tdm;

    localparam int N        = 32;
    localparam int TAPS     = 4;
    localparam int CHANNELS = 3;
    localparam int FRAC     = 16;
    localparam int CH_W     = 2;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [N-1:0]    y;
        int              acceptCycle;
        int              expLat;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    logic            clk       = 1'b0;
    logic            rst       = 1'b0;
    logic            ena       = 1'b0;
    logic            coef_we   = 1'b0;
    logic [1:0]      coef_addr = '0;
    logic [N-1:0]    coef_data = '0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [CH_W-1:0] in_ch     = '0;
    logic [N-1:0]    x_in      = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CH_W-1:0] out_ch;
    logic [N-1:0]    y_out;
    logic            busy;

    int   cycleCnt    = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   riseCycle   = 0;
    logic prevValid   = 1'b0;

    fir_mc_tdm #(
        .N        (N),
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS),
        .FRAC     (FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic writeCoef(input logic [1:0] addr, input logic [N-1:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [N-1:0] x,
                                 input logic expectOut, input logic [N-1:0] expY, input int expLat);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_ch    = ch;
        x_in     = x;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        if (expectOut) begin
            sbQ.push_back('{ch, expY, cycleCnt, expLat});
        end
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((sbQ.size() != 0 || busy) && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput("drain", (sbQ.size() == 0 && !busy) ? 64'd1 : 64'd0, 64'd1);
    endtask

    // Output monitor: a handshake completes on the edge after a negedge that sees valid && ready.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && !prevValid) begin
                riseCycle = cycleCnt;
            end
            prevValid = out_valid;
            if (rst && ena && out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spuriousOutput", 64'd1, 64'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("y_out", y_out, e.y);
                    checkOutput("out_ch", out_ch, e.ch);
                    checkOutput("latency", riseCycle - e.acceptCycle, e.expLat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;

        rst       = 1'b0;
        ena       = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rstInReady", in_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstY", y_out, 0);
        checkOutput("rstOutCh", out_ch, 0);
        checkOutput("rstBusy", busy, 0);
        rst = 1'b1;
        #1;
        checkOutput("idleInReady", in_ready, 1);
        checkOutput("idleBusy", busy, 0);
        tick();
        ena = 1'b0;
        #1;
        checkOutput("enaLowInReady", in_ready, 0);
        ena = 1'b1;
        tick();

        $display("[TB] impulse response");
        writeCoef(2'd0, 32'h0001_0000);
        writeCoef(2'd1, 32'h0000_8000);
        writeCoef(2'd2, 32'hFFFF_C000);
        writeCoef(2'd3, 32'h0002_0000);
        applyStimulus(2'd0, 32'h0001_0000, 1'b1, 32'h0001_0000, 5);
        applyStimulus(2'd0, 32'h0,         1'b1, 32'h0000_8000, 5);
        applyStimulus(2'd0, 32'h0,         1'b1, 32'hFFFF_C000, 5);
        applyStimulus(2'd0, 32'h0,         1'b1, 32'h0002_0000, 5);
        waitDrain();

        $display("[TB] channel isolation");
        for (int t = 0; t < TAPS; t++) begin
            writeCoef(2'(t), 32'h0001_0000);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'd0, (k == 0) ? 32'h0001_0000 : 32'h0, 1'b1, 32'h0001_0000, 5);
            applyStimulus(2'd1, 32'h0001_0000, 1'b1, N'(32'h0001_0000 * (k + 1)), 5);
        end
        waitDrain();
        applyStimulus(2'd3, 32'h0005_5555, 1'b0, 32'h0, 0);
        checkOutput("dropBusyNow", busy, 0);
        repeat (8) tick();
        checkOutput("dropBusyLater", busy, 0);
        checkOutput("dropOutValid", out_valid, 0);

        $display("[TB] rounding and saturation");
        writeCoef(2'd0, 32'h0000_0001);
        writeCoef(2'd1, 32'h0);
        writeCoef(2'd2, 32'h0);
        writeCoef(2'd3, 32'h0);
        applyStimulus(2'd2, 32'h0000_8000, 1'b1, 32'h0000_0001, 5);
        waitDrain();
        writeCoef(2'd0, 32'h7FFF_FFFF);
        applyStimulus(2'd2, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 5);
        applyStimulus(2'd2, 32'h8000_0000, 1'b1, 32'h8000_0000, 5);
        waitDrain();

        $display("[TB] backpressure");
        writeCoef(2'd0, 32'h0001_0000);
        writeCoef(2'd1, 32'h0000_8000);
        writeCoef(2'd2, 32'hFFFF_C000);
        writeCoef(2'd3, 32'h0002_0000);
        out_ready = 1'b0;
        applyStimulus(2'd0, 32'h0003_0000, 1'b1, 32'h0003_0000, 5);
        for (int w = 0; w < 20 && !out_valid; w++) begin
            tick();
        end
        checkOutput("bpOutValid", out_valid, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("bpHoldY", y_out, 32'h0003_0000);
            checkOutput("bpInReady", in_ready, 0);
        end
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] enable stall during MAC");
        applyStimulus(2'd0, 32'h0001_0000, 1'b1, 32'h0002_8000, 8);
        tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
        waitDrain();

        $display("[TB] coefficient write guard");
        coef_we   = 1'b1;
        coef_addr = 2'd3;
        coef_data = 32'h0;
        applyStimulus(2'd1, 32'h0001_0000, 1'b1, 32'h0001_4000, 5);
        coef_we   = 1'b0;
        applyStimulus(2'd1, 32'h0001_0000, 1'b1, 32'h0001_4000, 5);
        tick();
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 32'h0005_0000;
        tick();
        tick();
        coef_we   = 1'b0;
        waitDrain();
        applyStimulus(2'd1, 32'h0001_0000, 1'b1, 32'h0001_4000, 5);
        waitDrain();

        $display("[TB] reset abort");
        applyStimulus(2'd0, 32'h0001_0000, 1'b0, 32'h0, 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortInReady", in_ready, 0);
        checkOutput("abortOutValid", out_valid, 0);
        checkOutput("abortY", y_out, 0);
        tick();
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abortNoOutput", sawValid, 0);
        applyStimulus(2'd2, 32'h0001_0000, 1'b1, 32'h0, 5);
        waitDrain();
        for (int t = 0; t < TAPS; t++) begin
            writeCoef(2'(t), 32'h0001_0000);
        end
        applyStimulus(2'd1, 32'h0,         1'b1, 32'h0,         5);
        applyStimulus(2'd0, 32'h0002_0000, 1'b1, 32'h0002_0000, 5);
        applyStimulus(2'd2, 32'h0,         1'b1, 32'h0001_0000, 5);
        waitDrain();

        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_mc_tdm.md
# fir_mc_tdm

Time-multiplexed, multi-channel FIR filter: successor to the fully parallel tapped-delay FIR chain, replacing one multiplier per tap with a single shared multiply-accumulate unit iterated over TAPS cycles. It adds:
- a run-time coefficient write port;
- per-channel delay lines;
- valid/ready handshakes on input and output;
- round-and-saturate output scaling.

It sits between a sample source and a downstream consumer in the signal path.

## Interface
Parameters:
- N, 32, signed data and coefficient width
- TAPS, 4, filter length (≥2)
- CHANNELS, 2, independent channels sharing one coefficient set (≥1)
- FRAC, 16, fractional bits of coefficients (1 ≤ FRAC < N)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes FSM, counters, handshakes
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index
- coef_data  in  N  signed coefficient
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_ch  in  max(1,$clog2(CHANNELS))  channel of offered sample
- x_in  in  N  signed sample
- out_valid  out  1  result offered
- out_ready  in  1  consumer accepts
- out_ch  out  max(1,$clog2(CHANNELS))  channel of result
- y_out  out  N  signed filtered result
- busy  out  1  high whenever FSM not IDLE

## Operation
- Storage: coef[TAPS]; per channel a delay line x[ch][0..TAPS-1], x[ch][0] newest.
- FSM states:
  - IDLE: in_ready = ena.
    - On accept with in_ch < CHANNELS: shift x[in_ch] (x_in → slot 0, oldest dropped), latch ch, acc ← 0, tap ← 0, go MAC.
    - On accept with in_ch ≥ CHANNELS: discard sample, stay IDLE, no output.
  - MAC: each enabled cycle acc ← acc + coef[tap]·x[ch][tap], tap++. After tap = TAPS-1 accumulates, go FIN.
  - FIN: y_out ← sat(round(acc)), out_ch ← ch, out_valid ← 1, go OUT.
  - OUT: hold y_out/out_ch/out_valid stable until out_ready && ena, then out_valid ← 0, go IDLE.
- Arithmetic:
  - Products are 2N bits, full precision.
  - acc width is 2N + $clog2(TAPS), so it cannot overflow.
  - round = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +∞.
  - sat clamps to [-2^(N-1), 2^(N-1)-1].
- Coefficient write:
  - Honoured only when state is IDLE (independent of ena) and coef_addr < TAPS.
  - Otherwise silently dropped.
  - A write in the same cycle as a sample accept is honoured; the new coefficient is used by that computation.
- ena low: no state, counter, delay-line or output change; out_valid and y_out hold. Coefficient writes in IDLE still land.
- Delay-line contents persist across samples; channels never interact.

## Timing
- Reset (rst low, async): state IDLE, all coef and delay lines 0, acc 0, in_ready 0 during reset, out_valid 0, y_out 0, out_ch 0, busy 0. After release, in_ready follows ena.
- Accept at edge E0. Accumulations occur on E1..E_TAPS. FIN at E_TAPS+1 sets out_valid. First result is visible TAPS+1 edges after accept.
- With out_ready held high: OUT→IDLE at E_TAPS+2, next accept at E_TAPS+3. Sustained throughput is one sample per TAPS+3 cycles.
- out_ready low holds OUT indefinitely (backpressure). in_ready stays 0 until IDLE.
- Reset asserted mid-operation aborts the computation; no partial output is ever produced.

## Structure
- Package fir_pkg holds:
  - state enum (IDLE, MAC, FIN, OUT);
  - width helper functions: acc width, channel index width;
  - the round/saturate function.
- Sub-module fir_round_sat (combinational, parameters N, FRAC, acc width): round plus saturate, shared with future FIR variants.
- Delay lines are a register array indexed [ch][tap]; no RAM macro required.

## Test plan
Defaults apply unless stated (N=32, TAPS=4, CHANNELS=2, FRAC=16).
- Reset/idle: hold rst low, then release with ena=1 → all outputs 0, in_ready=1, busy=0.
- Impulse response: coef = {1.0, 0.5, -0.25, 2.0} (0x10000, 0x8000, 0xFFFFC000, 0x20000), ch0 samples 0x10000, 0, 0, 0 → y_out 0x10000, 0x8000, 0xFFFFC000, 0x20000. Each result arrives exactly 5 edges after its accept.
- Rounding and saturation:
  - coef[0]=0x1, others 0, x=0x8000 → acc 0x8000, y=1 (half rounds up).
  - coef[0]=0x7FFFFFFF, x=0x7FFFFFFF → y=0x7FFFFFFF.
  - coef[0]=0x7FFFFFFF, x=0x80000000 → y=0x80000000.
- Channel isolation: interleave ch0 impulse with ch1 constant 0x10000 (coef all 0x10000) → ch1 outputs 0x10000, 0x20000, 0x30000, 0x40000; ch0 outputs unaffected; out_ch correct. in_ch=3 with CHANNELS=3 → dropped, no output.
- Backpressure/ena: hold out_ready low 10 cycles → y_out stable, in_ready 0. Drop ena mid-MAC for 3 cycles → result identical to the uninterrupted case, 3 cycles later.
- Coefficient guard and reset abort:
  - coef_we during MAC → ignored; the following result uses the old coefficient.
  - rst pulse during MAC → out_valid never asserts; all state returns to reset values.
